n1_pbus_arb: RTL and testbench

Two-requester arbiter for the N1 pipelined Wishbone program bus (PBUS). Requester 0 is the flow-control fetch/memory-I/O port; requester 1 is the debug/DMA port. The block grants exclusive bus ownership per bus cycle (CYC) and tracks outstanding pipelined accesses. A response watchdog aborts hung cycles. It sits between the N1 core/debug logic and the single PBUS target.

---
 rtl/n1_pbus_arb_pkg.sv | 23 ++
 rtl/n1_pbus_arb_cnt.sv | 45 ++++
 rtl/n1_pbus_arb.sv | 180 ++++++++++++++++++
 tb/tb_n1_pbus_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/n1_pbus_arb_pkg.sv
// Shared types for the N1 PBUS two-requester arbiter: FSM state encoding,
// requester index and counter width helper.
package n1_pbus_arb_pkg;

  // Encoding is visible on prb_arb_state_o, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_e;

  typedef logic req_idx_t;

  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/n1_pbus_arb_cnt.sv
// Outstanding-access counter and response watchdog for the PBUS arbiter.
// clr has priority; inc and dec together leave the count unchanged.
module n1_pbus_arb_cnt
  import n1_pbus_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 3,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned OW = cnt_width(MAX_OUTST),
  localparam int unsigned WW = cnt_width(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  input  logic          run,
  output logic [OW-1:0] outst,
  output logic          full,
  output logic          expire
);

  logic [WW-1:0] wd;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      outst <= '0;
      wd    <= '0;
    end else begin
      if (inc && !dec && !full)
        outst <= outst + 1'b1;
      else if (dec && !inc && outst != '0)
        outst <= outst - 1'b1;

      // Saturates at TIMEOUT so expire holds until the FSM reacts.
      if (dec)
        wd <= '0;
      else if (run && outst != '0 && wd != WW'(TIMEOUT))
        wd <= wd + 1'b1;
    end
  end

  assign full   = (outst == OW'(MAX_OUTST));
  assign expire = (TIMEOUT != 0) && (wd == WW'(TIMEOUT));

endmodule

// File: rtl/n1_pbus_arb.sv
// N1 PBUS arbiter: grants the single pipelined Wishbone target to requester 0
// (fetch/memory I/O) or requester 1 (debug/DMA) per bus cycle, with a watchdog.
module n1_pbus_arb
  import n1_pbus_arb_pkg::*;
#(
  parameter int unsigned PBUS_AW   = 14,
  parameter int unsigned PBUS_DW   = 16,
  parameter int unsigned MAX_OUTST = 3,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned RR_EN     = 1
) (
  input  logic                           clk_i,
  input  logic                           sync_rst_i,

  input  logic                           m0_cyc_i,
  input  logic                           m0_stb_i,
  input  logic                           m0_we_i,
  input  logic [PBUS_AW-1:0]             m0_adr_i,
  input  logic [PBUS_DW-1:0]             m0_dat_i,
  output logic                           m0_ack_o,
  output logic                           m0_err_o,
  output logic                           m0_rty_o,
  output logic                           m0_stall_o,

  input  logic                           m1_cyc_i,
  input  logic                           m1_stb_i,
  input  logic                           m1_we_i,
  input  logic [PBUS_AW-1:0]             m1_adr_i,
  input  logic [PBUS_DW-1:0]             m1_dat_i,
  output logic                           m1_ack_o,
  output logic                           m1_err_o,
  output logic                           m1_rty_o,
  output logic                           m1_stall_o,

  output logic                           pbus_cyc_o,
  output logic                           pbus_stb_o,
  output logic                           pbus_we_o,
  output logic [PBUS_AW-1:0]             pbus_adr_o,
  output logic [PBUS_DW-1:0]             pbus_dat_o,
  input  logic                           pbus_ack_i,
  input  logic                           pbus_err_i,
  input  logic                           pbus_rty_i,
  input  logic                           pbus_stall_i,

  output logic [1:0]                     prb_arb_state_o,
  output logic [$clog2(MAX_OUTST+1)-1:0] prb_arb_outst_o
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  arb_state_e    state;
  req_idx_t      last_grant;
  req_idx_t      owner;
  logic          own;
  logic          own_cyc;
  logic          own_stb;
  logic          oth_cyc;
  logic          grant1;
  logic          rsp;
  logic          full;
  logic          expire;
  logic          inc;
  logic          dec;
  logic          clr;
  logic [OW-1:0] outst;

  assign own = (state == ST_OWN0) || (state == ST_OWN1);
  assign rsp = pbus_ack_i | pbus_err_i | pbus_rty_i;

  // In ABORT the aborted owner has already been latched into last_grant.
  always_comb begin
    owner = REQ0;
    if (state == ST_OWN1)
      owner = REQ1;
    else if (state == ST_ABORT)
      owner = last_grant;
  end

  assign own_cyc = (owner == REQ1) ? m1_cyc_i : m0_cyc_i;
  assign own_stb = (owner == REQ1) ? m1_stb_i : m0_stb_i;
  assign oth_cyc = (owner == REQ1) ? m0_cyc_i : m1_cyc_i;

  always_comb begin
    if (m0_cyc_i && m1_cyc_i)
      grant1 = (RR_EN != 0) && (last_grant == REQ0);
    else
      grant1 = m1_cyc_i;
  end

  always_comb begin
    pbus_cyc_o = 1'b0;
    pbus_stb_o = 1'b0;
    pbus_we_o  = 1'b0;
    pbus_adr_o = '0;
    pbus_dat_o = '0;
    m0_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_rty_o   = 1'b0;
    m1_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_rty_o   = 1'b0;
    if (own) begin
      pbus_cyc_o = own_cyc;
      pbus_stb_o = own_cyc & own_stb & ~full;
      pbus_we_o  = (owner == REQ1) ? m1_we_i  : m0_we_i;
      pbus_adr_o = (owner == REQ1) ? m1_adr_i : m0_adr_i;
      pbus_dat_o = (owner == REQ1) ? m1_dat_i : m0_dat_i;
      if (owner == REQ1) begin
        m1_stall_o = pbus_stall_i | full;
        m1_ack_o   = pbus_ack_i;
        m1_err_o   = pbus_err_i;
        m1_rty_o   = pbus_rty_i;
      end else begin
        m0_stall_o = pbus_stall_i | full;
        m0_ack_o   = pbus_ack_i;
        m0_err_o   = pbus_err_i;
        m0_rty_o   = pbus_rty_i;
      end
    end else if (state == ST_ABORT) begin
      if (owner == REQ1)
        m1_err_o = 1'b1;
      else
        m0_err_o = 1'b1;
    end
  end

  assign inc = pbus_stb_o & ~pbus_stall_i;
  assign dec = own & rsp;
  assign clr = (own & (~own_cyc | expire)) | (state == ST_ABORT);

  n1_pbus_arb_cnt #(
    .MAX_OUTST (MAX_OUTST),
    .TIMEOUT   (TIMEOUT)
  ) u_cnt (
    .clk    (clk_i),
    .rst    (sync_rst_i),
    .inc    (inc),
    .dec    (dec),
    .clr    (clr),
    .run    (own),
    .outst  (outst),
    .full   (full),
    .expire (expire)
  );

  // Release takes precedence over a watchdog expiry in the same cycle.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state      <= ST_IDLE;
      last_grant <= REQ1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_cyc_i || m1_cyc_i)
            state <= grant1 ? ST_OWN1 : ST_OWN0;
        end
        ST_OWN0, ST_OWN1: begin
          if (!own_cyc) begin
            last_grant <= owner;
            if (oth_cyc)
              state <= (owner == REQ0) ? ST_OWN1 : ST_OWN0;
            else
              state <= ST_IDLE;
          end else if (expire) begin
            last_grant <= owner;
            state      <= ST_ABORT;
          end
        end
        ST_ABORT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign prb_arb_state_o = state;
  assign prb_arb_outst_o = outst;

endmodule

// File: tb/tb_n1_pbus_arb.sv
// Bench for n1_pbus_arb: a round-robin/TIMEOUT=8 instance and a fixed-priority/
// no-watchdog instance share stimulus and are checked each cycle against a model.
module tb_n1_pbus_arb;
  localparam int AW   = 14;
  localparam int DW   = 16;
  localparam int MAXO = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    cyc, stb, we;
  logic [AW-1:0] adr [2];
  logic [DW-1:0] dat [2];
  logic          pack, perr, prty, pstall;

  logic          o_cyc [2];
  logic          o_stb [2];
  logic          o_we  [2];
  logic [AW-1:0] o_adr [2];
  logic [DW-1:0] o_dat [2];
  logic [1:0]    o_ack [2];
  logic [1:0]    o_err [2];
  logic [1:0]    o_rty [2];
  logic [1:0]    o_stall [2];
  logic [1:0]    o_st  [2];
  logic [1:0]    o_out [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic a0, a1, e0, e1, r0, r1, s0, s1;
    n1_pbus_arb #(
      .PBUS_AW   (AW),
      .PBUS_DW   (DW),
      .MAX_OUTST (MAXO),
      .TIMEOUT   ((k == 0) ? 8 : 0),
      .RR_EN     ((k == 0) ? 1 : 0)
    ) u_dut (
      .clk_i           (clk),
      .sync_rst_i      (rst),
      .m0_cyc_i        (cyc[0]),
      .m0_stb_i        (stb[0]),
      .m0_we_i         (we[0]),
      .m0_adr_i        (adr[0]),
      .m0_dat_i        (dat[0]),
      .m0_ack_o        (a0),
      .m0_err_o        (e0),
      .m0_rty_o        (r0),
      .m0_stall_o      (s0),
      .m1_cyc_i        (cyc[1]),
      .m1_stb_i        (stb[1]),
      .m1_we_i         (we[1]),
      .m1_adr_i        (adr[1]),
      .m1_dat_i        (dat[1]),
      .m1_ack_o        (a1),
      .m1_err_o        (e1),
      .m1_rty_o        (r1),
      .m1_stall_o      (s1),
      .pbus_cyc_o      (o_cyc[k]),
      .pbus_stb_o      (o_stb[k]),
      .pbus_we_o       (o_we[k]),
      .pbus_adr_o      (o_adr[k]),
      .pbus_dat_o      (o_dat[k]),
      .pbus_ack_i      (pack),
      .pbus_err_i      (perr),
      .pbus_rty_i      (prty),
      .pbus_stall_i    (pstall),
      .prb_arb_state_o (o_st[k]),
      .prb_arb_outst_o (o_out[k])
    );
    assign o_ack[k]   = {a1, a0};
    assign o_err[k]   = {e1, e0};
    assign o_rty[k]   = {r1, r0};
    assign o_stall[k] = {s1, s0};
  end

  // Model state: st is the probe value (0 idle, 1/2 = owner+1, 3 abort).
  int m_st [2];
  int m_out [2];
  int m_wd [2];
  int m_last [2];
  int p_to [2] = '{8, 0};
  int p_rr [2] = '{1, 0};

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_out[k] = 0; m_wd[k] = 0; m_last[k] = 1;
    end
  endtask

  task automatic check_inst(input int k);
    logic          ecyc, estb, ewe;
    logic [AW-1:0] eadr;
    logic [DW-1:0] edat;
    logic [1:0]    eack, eerr, erty, estall;
    int o, win;
    bit full, rsp, acc, expire;
    string t;
    t = (k == 0) ? "rr" : "fx";
    ecyc = 0; estb = 0; ewe = 0; eadr = '0; edat = '0;
    eack = '0; eerr = '0; erty = '0; estall = 2'b11;
    o = 0;
    full = (m_out[k] == MAXO);
    if (m_st[k] == 1 || m_st[k] == 2) begin
      o = m_st[k] - 1;
      ecyc = cyc[o];
      estb = cyc[o] & stb[o] & !full;
      ewe  = we[o];
      eadr = adr[o];
      edat = dat[o];
      estall[o] = pstall | full;
      eack[o] = pack;
      eerr[o] = perr;
      erty[o] = prty;
    end else if (m_st[k] == 3) begin
      eerr[m_last[k]] = 1'b1;
    end

    check_val({t, ".state"}, o_st[k], m_st[k]);
    check_val({t, ".outst"}, o_out[k], m_out[k]);
    check_val({t, ".cyc"}, o_cyc[k], ecyc);
    check_val({t, ".stb"}, o_stb[k], estb);
    check_val({t, ".we"}, o_we[k], ewe);
    check_val({t, ".adr"}, o_adr[k], eadr);
    check_val({t, ".dat"}, o_dat[k], edat);
    check_val({t, ".ack"}, o_ack[k], eack);
    check_val({t, ".err"}, o_err[k], eerr);
    check_val({t, ".rty"}, o_rty[k], erty);
    check_val({t, ".stall"}, o_stall[k], estall);

    if (rst) begin
      m_st[k] = 0; m_out[k] = 0; m_wd[k] = 0; m_last[k] = 1;
    end else if (m_st[k] == 0) begin
      if (cyc != 2'b00) begin
        if (cyc == 2'b11) win = (p_rr[k] != 0) ? 1 - m_last[k] : 0;
        else win = cyc[0] ? 0 : 1;
        m_st[k] = win + 1;
      end
    end else if (m_st[k] == 3) begin
      m_st[k] = 0; m_out[k] = 0; m_wd[k] = 0;
    end else begin
      rsp = pack | perr | prty;
      acc = estb & !pstall;
      expire = (p_to[k] != 0) && (m_wd[k] == p_to[k]);
      if (!cyc[o]) begin
        m_last[k] = o; m_out[k] = 0; m_wd[k] = 0;
        m_st[k] = cyc[1 - o] ? (2 - o) : 0;
      end else if (expire) begin
        m_last[k] = o; m_out[k] = 0; m_wd[k] = 0; m_st[k] = 3;
      end else begin
        if (rsp) m_wd[k] = 0;
        else if (m_out[k] > 0 && m_wd[k] < p_to[k]) m_wd[k]++;
        if (acc && !rsp) m_out[k]++;
        else if (rsp && !acc && m_out[k] > 0) m_out[k]--;
      end
    end
  endtask

  // Inputs are set right after a falling edge; compare, advance model, next negedge.
  task automatic step();
    #2;
    for (int k = 0; k < 2; k++) check_inst(k);
    @(negedge clk);
  endtask

  bit quiet;
  int rsel;

  initial begin
    rst = 1'b1; cyc = '0; stb = '0; we = '0;
    adr[0] = '0; adr[1] = '0; dat[0] = '0; dat[1] = '0;
    pack = 0; perr = 0; prty = 0; pstall = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // single requester, address 0x0100, ack two cycles after the strobe
    cyc = 2'b01; adr[0] = 14'h0100; dat[0] = 16'hbeef; we[0] = 1'b1;
    step();
    stb = 2'b01; step();
    stb = 2'b00; step();
    pack = 1; step();
    pack = 0; cyc = 2'b00; step();
    step();

    // simultaneous requests, release and re-request
    cyc = 2'b11; adr[1] = 14'h0222; repeat (3) step();
    cyc = 2'b10; repeat (2) step();
    cyc = 2'b11; repeat (3) step();
    cyc = 2'b01; repeat (2) step();
    cyc = 2'b00; step();

    // four back-to-back strobes against MAX_OUTST, then one ack, then silence
    cyc = 2'b01; step();
    stb = 2'b01; repeat (4) step();
    stb = 2'b00; pack = 1; step();
    pack = 0; stb = 2'b01; step();
    stb = 2'b00; repeat (12) step();
    cyc = 2'b00; step();

    // reset in the middle of an OWN1 cycle with accesses in flight
    cyc = 2'b10; step();
    stb = 2'b10; repeat (2) step();
    stb = 2'b00; rst = 1'b1; step();
    rst = 1'b0; step();
    cyc = 2'b00; step();

    for (int i = 0; i < 3000; i++) begin
      quiet = (i % 120) >= 80;
      rst = ($urandom_range(599) == 0);
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(quiet ? 31 : 7) == 0) cyc[r] = ~cyc[r];
        stb[r] = cyc[r] & 1'($urandom_range(1));
        we[r]  = 1'($urandom);
        adr[r] = AW'($urandom);
        dat[r] = DW'($urandom);
      end
      pstall = ($urandom_range(3) == 0);
      rsel = quiet ? 9 : $urandom_range(6);
      pack = (rsel == 0);
      perr = (rsel == 1);
      prty = (rsel == 2);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
